// File: rtl/axi4_burst_write_master_if.sv
// Bundle of the command, beat-stream, completion and AXI write-channel
// signals of one burst write initiator. The master modport is the initiator's
// view. The slave modport is the view of the surrounding logic and the
// interconnect slot.
interface axi4_burst_write_master_if #(
  parameter int C_AXI_ID_WIDTH   = 1,
  parameter int C_AXI_ADDR_WIDTH = 32,
  parameter int C_AXI_DATA_WIDTH = 32,
  parameter int C_AXI_PROTOCOL   = 0
);
  localparam int LW = (C_AXI_PROTOCOL == 1) ? 4 : 8;
  localparam int KW = (C_AXI_PROTOCOL == 1) ? 2 : 1;
  localparam int SW = C_AXI_DATA_WIDTH / 8;

  // local command
  logic                        cmd_valid;
  logic                        cmd_ready;
  logic [C_AXI_ADDR_WIDTH-1:0] cmd_addr;
  logic [LW-1:0]               cmd_len;
  logic [C_AXI_ID_WIDTH-1:0]   cmd_id;
  // local beat stream
  logic [C_AXI_DATA_WIDTH-1:0] wr_data;
  logic [SW-1:0]               wr_strb;
  logic                        wr_valid;
  logic                        wr_ready;
  // completion
  logic                        done_valid;
  logic [1:0]                  done_resp;
  logic                        done_idmis;
  // AW channel
  logic [C_AXI_ID_WIDTH-1:0]   m_axi_awid;
  logic [C_AXI_ADDR_WIDTH-1:0] m_axi_awaddr;
  logic [LW-1:0]               m_axi_awlen;
  logic [2:0]                  m_axi_awsize;
  logic [1:0]                  m_axi_awburst;
  logic [KW-1:0]               m_axi_awlock;
  logic [3:0]                  m_axi_awcache;
  logic [2:0]                  m_axi_awprot;
  logic [3:0]                  m_axi_awqos;
  logic                        m_axi_awvalid;
  logic                        m_axi_awready;
  // W channel
  logic [C_AXI_ID_WIDTH-1:0]   m_axi_wid;
  logic [C_AXI_DATA_WIDTH-1:0] m_axi_wdata;
  logic [SW-1:0]               m_axi_wstrb;
  logic                        m_axi_wlast;
  logic                        m_axi_wvalid;
  logic                        m_axi_wready;
  // B channel
  logic [C_AXI_ID_WIDTH-1:0]   m_axi_bid;
  logic [1:0]                  m_axi_bresp;
  logic                        m_axi_bvalid;
  logic                        m_axi_bready;

  modport master (
    input  cmd_valid, cmd_addr, cmd_len, cmd_id,
    output cmd_ready,
    input  wr_data, wr_strb, wr_valid,
    output wr_ready,
    output done_valid, done_resp, done_idmis,
    output m_axi_awid, m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst,
    output m_axi_awlock, m_axi_awcache, m_axi_awprot, m_axi_awqos, m_axi_awvalid,
    input  m_axi_awready,
    output m_axi_wid, m_axi_wdata, m_axi_wstrb, m_axi_wlast, m_axi_wvalid,
    input  m_axi_wready,
    input  m_axi_bid, m_axi_bresp, m_axi_bvalid,
    output m_axi_bready
  );

  modport slave (
    output cmd_valid, cmd_addr, cmd_len, cmd_id,
    input  cmd_ready,
    output wr_data, wr_strb, wr_valid,
    input  wr_ready,
    input  done_valid, done_resp, done_idmis,
    input  m_axi_awid, m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst,
    input  m_axi_awlock, m_axi_awcache, m_axi_awprot, m_axi_awqos, m_axi_awvalid,
    output m_axi_awready,
    input  m_axi_wid, m_axi_wdata, m_axi_wstrb, m_axi_wlast, m_axi_wvalid,
    output m_axi_wready,
    output m_axi_bid, m_axi_bresp, m_axi_bvalid,
    input  m_axi_bready
  );
endinterface

// File: rtl/axi4_burst_write_master.sv
// Single-outstanding INCR burst write initiator. It takes one command,
// issues AW, streams the local beats onto W and reports the B response.
module axi4_burst_write_master #(
  parameter int C_AXI_ID_WIDTH   = 1,
  parameter int C_AXI_ADDR_WIDTH = 32,
  parameter int C_AXI_DATA_WIDTH = 32,
  parameter int C_AXI_PROTOCOL   = 0
) (
  input logic clk,
  input logic rst,
  axi4_burst_write_master_if.master bus
);
  localparam int LW = (C_AXI_PROTOCOL == 1) ? 4 : 8;
  localparam logic [2:0] AWSIZE = (C_AXI_DATA_WIDTH == 128) ? 3'd4 :
                                  (C_AXI_DATA_WIDTH == 64)  ? 3'd3 : 3'd2;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ADDR = 2'd1;
  localparam logic [1:0] S_DATA = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;

  logic [1:0]                  r_state;
  logic [C_AXI_ADDR_WIDTH-1:0] r_addr;
  logic [LW-1:0]               r_len;
  logic [LW-1:0]               r_cnt;
  logic [C_AXI_ID_WIDTH-1:0]   r_id;
  logic                        r_done_valid;
  logic [1:0]                  r_done_resp;
  logic                        r_done_idmis;

  logic w_cmd_hs;
  logic w_in_data;
  logic w_last;
  logic w_w_hs;
  logic w_b_hs;

  assign w_cmd_hs  = (r_state == S_IDLE) && bus.cmd_valid;
  assign w_in_data = (r_state == S_DATA);
  assign w_last    = w_in_data && (r_cnt == r_len);
  assign w_w_hs    = w_in_data && bus.wr_valid && bus.m_axi_wready;
  assign w_b_hs    = (r_state == S_RESP) && bus.m_axi_bvalid;

  // Burst sequencing: command -> address -> beats -> response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (bus.cmd_valid)     r_state <= S_ADDR;
        S_ADDR:  if (bus.m_axi_awready) r_state <= S_DATA;
        S_DATA:  if (w_w_hs && w_last)  r_state <= S_RESP;
        S_RESP:  if (bus.m_axi_bvalid)  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Latch the command on acceptance; count W beats within the burst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr <= '0;
      r_len  <= '0;
      r_id   <= '0;
      r_cnt  <= '0;
    end else if (w_cmd_hs) begin
      r_addr <= bus.cmd_addr;
      r_len  <= bus.cmd_len;
      r_id   <= bus.cmd_id;
      r_cnt  <= '0;
    end else if (w_w_hs) begin
      r_cnt  <= r_cnt + {{(LW-1){1'b0}}, 1'b1};
    end
  end

  // Capture the B response and raise a one-cycle completion pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_done_valid <= 1'b0;
      r_done_resp  <= 2'b00;
      r_done_idmis <= 1'b0;
    end else begin
      r_done_valid <= w_b_hs;
      if (w_b_hs) begin
        r_done_resp  <= bus.m_axi_bresp;
        r_done_idmis <= (bus.m_axi_bid != r_id);
      end
    end
  end

  // cmd_ready is also masked by rst so it reads low during reset.
  assign bus.cmd_ready  = (r_state == S_IDLE) && !rst;
  assign bus.done_valid = r_done_valid;
  assign bus.done_resp  = r_done_resp;
  assign bus.done_idmis = r_done_idmis;

  assign bus.m_axi_awid    = r_id;
  assign bus.m_axi_awaddr  = r_addr;
  assign bus.m_axi_awlen   = r_len;
  assign bus.m_axi_awsize  = AWSIZE;
  assign bus.m_axi_awburst = 2'b01;
  assign bus.m_axi_awlock  = '0;
  assign bus.m_axi_awcache = 4'b0011;
  assign bus.m_axi_awprot  = 3'b000;
  assign bus.m_axi_awqos   = 4'b0000;
  assign bus.m_axi_awvalid = (r_state == S_ADDR);

  // The beat path is combinational so a beat can pass every cycle.
  assign bus.m_axi_wid    = r_id;
  assign bus.m_axi_wdata  = bus.wr_data;
  assign bus.m_axi_wstrb  = bus.wr_strb;
  assign bus.m_axi_wlast  = w_last;
  assign bus.m_axi_wvalid = w_in_data && bus.wr_valid;
  assign bus.wr_ready     = w_in_data && bus.m_axi_wready;

  assign bus.m_axi_bready = (r_state == S_RESP);
endmodule

// File: tb/tb_axi4_burst_write_master.sv
// Directed bench for the burst write initiator: a per-cycle vector table for
// single bursts, plus hand sequences for gapped beats, back-to-back commands,
// an AXI3 build and reset in mid-burst.
module tb_axi4_burst_write_master;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  axi4_burst_write_master_if #(.C_AXI_PROTOCOL(0)) b0 ();
  axi4_burst_write_master_if #(.C_AXI_PROTOCOL(1)) b1 ();

  axi4_burst_write_master #(.C_AXI_PROTOCOL(0)) u0 (.clk(clk), .rst(rst), .bus(b0));
  axi4_burst_write_master #(.C_AXI_PROTOCOL(1)) u1 (.clk(clk), .rst(rst), .bus(b1));

  typedef struct packed {
    logic        cv;  logic [31:0] addr; logic [7:0] len; logic id;
    logic        wv;  logic [31:0] wd;
    logic        awr; logic wr; logic bv; logic bid; logic [1:0] bresp;
    logic        ecr; logic eaw; logic [31:0] eaddr; logic [7:0] elen;
    logic        ewv; logic ewl; logic [31:0] ewd;
    logic        ewrr; logic ebr; logic edn; logic [1:0] eresp; logic eidm;
  } vec_t;

  typedef struct packed {
    logic [31:0] d;
    logic        l;
  } beat_t;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  int wid_err = 0;
  int proto_err0 = 0;
  beat_t beats0[$];
  beat_t beats1[$];
  logic [7:0] aw_len0[$];
  int aw_cyc0[$];
  int done_cyc0[$];
  logic [3:0] aw_len1[$];
  vec_t vt[25];

  always @(posedge clk) cyc <= cyc + 1;

  // Observers: record every handshake seen on both instances.
  always @(negedge clk) begin
    beat_t bt;
    if (b0.m_axi_wvalid && b0.m_axi_wready) begin
      bt.d = b0.m_axi_wdata; bt.l = b0.m_axi_wlast;
      beats0.push_back(bt);
    end
    if (b0.m_axi_wvalid && !b0.wr_valid) proto_err0 = proto_err0 + 1;
    if (b0.wr_ready && !b0.m_axi_wready) proto_err0 = proto_err0 + 1;
    if (b0.m_axi_awvalid && b0.m_axi_awready) begin
      aw_len0.push_back(b0.m_axi_awlen);
      aw_cyc0.push_back(cyc);
    end
    if (b0.done_valid) done_cyc0.push_back(cyc);
    if (b1.m_axi_wvalid && b1.m_axi_wready) begin
      bt.d = b1.m_axi_wdata; bt.l = b1.m_axi_wlast;
      beats1.push_back(bt);
      if (b1.m_axi_wid != b1.m_axi_awid) wid_err = wid_err + 1;
    end
    if (b1.m_axi_awvalid && b1.m_axi_awready) aw_len1.push_back(b1.m_axi_awlen);
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One command on instance 0 with B always ready; optional W gaps.
  task automatic burst0(input logic [31:0] addr, input logic [7:0] len, input logic id,
                        input logic [31:0] dbase, input bit gap);
    int sent = 0;
    int k = 0;
    bit seen = 1'b0;
    b0.cmd_valid = 1'b1; b0.cmd_addr = addr; b0.cmd_len = len; b0.cmd_id = id;
    b0.m_axi_awready = 1'b1; b0.m_axi_bvalid = 1'b1; b0.m_axi_bid = id; b0.m_axi_bresp = 2'b00;
    while (!seen && k < 200) begin
      if (gap) begin
        b0.m_axi_wready = k[0];
        b0.wr_valid = ((k % 3) != 2);
      end else begin
        b0.m_axi_wready = 1'b1;
        b0.wr_valid = 1'b1;
      end
      b0.wr_data = dbase + sent;
      @(negedge clk);
      if (b0.m_axi_wvalid && b0.m_axi_wready) sent++;
      if (b0.done_valid) seen = 1'b1;
      tick();
      b0.cmd_valid = 1'b0;
      k++;
    end
    chk("burst0_done_seen", {127'd0, seen}, 128'd1);
    $display("burst addr=%0h len=%0d id=%0d beats=%0d cycles=%0d", addr, len, id, sent, k);
    b0.wr_valid = 1'b0; b0.m_axi_bvalid = 1'b0; b0.m_axi_awready = 1'b0; b0.m_axi_wready = 1'b0;
  endtask

  initial begin
    int base, ab, db, k, nd;
    bit seen;
    logic [127:0] act, exp;

    b0.cmd_valid = 0; b0.cmd_addr = 0; b0.cmd_len = 0; b0.cmd_id = 0;
    b0.wr_data = 0; b0.wr_strb = '1; b0.wr_valid = 0;
    b0.m_axi_awready = 0; b0.m_axi_wready = 0; b0.m_axi_bid = 0; b0.m_axi_bresp = 0; b0.m_axi_bvalid = 0;
    b1.cmd_valid = 0; b1.cmd_addr = 0; b1.cmd_len = 0; b1.cmd_id = 0;
    b1.wr_data = 0; b1.wr_strb = '1; b1.wr_valid = 0;
    b1.m_axi_awready = 0; b1.m_axi_wready = 0; b1.m_axi_bid = 0; b1.m_axi_bresp = 0; b1.m_axi_bvalid = 0;

    //            cv addr     len  id  wv wd      awr wr bv bid resp| ecr eaw eaddr    elen ewv ewl ewd    wrr br dn resp idm
    vt[0]  = '{1'b0, 32'h0,    8'd0, 1'b0, 1'b0, 32'h0,  1'b0,1'b0,1'b0,1'b0,2'd0, 1'b1,1'b0, 32'h0,    8'd0, 1'b0,1'b0, 32'h0,  1'b0,1'b0,1'b0,2'd0,1'b0};
    vt[1]  = '{1'b1, 32'h1000, 8'd0, 1'b1, 1'b1, 32'hA0, 1'b1,1'b1,1'b1,1'b1,2'd0, 1'b1,1'b0, 32'h0,    8'd0, 1'b0,1'b0, 32'h0,  1'b0,1'b0,1'b0,2'd0,1'b0};
    vt[2]  = '{1'b0, 32'h0,    8'd0, 1'b0, 1'b1, 32'hA0, 1'b1,1'b1,1'b1,1'b1,2'd0, 1'b0,1'b1, 32'h1000, 8'd0, 1'b0,1'b0, 32'h0,  1'b0,1'b0,1'b0,2'd0,1'b0};
    vt[3]  = '{1'b0, 32'h0,    8'd0, 1'b0, 1'b1, 32'hA0, 1'b1,1'b1,1'b1,1'b1,2'd0, 1'b0,1'b0, 32'h1000, 8'd0, 1'b1,1'b1, 32'hA0, 1'b1,1'b0,1'b0,2'd0,1'b0};
    vt[4]  = '{1'b0, 32'h0,    8'd0, 1'b0, 1'b1, 32'hA0, 1'b1,1'b1,1'b1,1'b1,2'd0, 1'b0,1'b0, 32'h1000, 8'd0, 1'b0,1'b0, 32'h0,  1'b0,1'b1,1'b0,2'd0,1'b0};
    vt[5]  = '{1'b0, 32'h0,    8'd0, 1'b0, 1'b1, 32'hA0, 1'b1,1'b1,1'b1,1'b1,2'd0, 1'b1,1'b0, 32'h1000, 8'd0, 1'b0,1'b0, 32'h0,  1'b0,1'b0,1'b1,2'd0,1'b0};
    vt[6]  = '{1'b0, 32'h0,    8'd0, 1'b0, 1'b0, 32'h0,  1'b0,1'b0,1'b0,1'b0,2'd0, 1'b1,1'b0, 32'h1000, 8'd0, 1'b0,1'b0, 32'h0,  1'b0,1'b0,1'b0,2'd0,1'b0};
    vt[7]  = '{1'b1, 32'h2000, 8'd0, 1'b1, 1'b1, 32'hB1, 1'b1,1'b1,1'b0,1'b0,2'd0, 1'b1,1'b0, 32'h1000, 8'd0, 1'b0,1'b0, 32'h0,  1'b0,1'b0,1'b0,2'd0,1'b0};
    vt[8]  = '{1'b0, 32'h0,    8'd0, 1'b0, 1'b1, 32'hB1, 1'b1,1'b1,1'b0,1'b0,2'd0, 1'b0,1'b1, 32'h2000, 8'd0, 1'b0,1'b0, 32'h0,  1'b0,1'b0,1'b0,2'd0,1'b0};
    vt[9]  = '{1'b0, 32'h0,    8'd0, 1'b0, 1'b1, 32'hB1, 1'b1,1'b1,1'b0,1'b0,2'd0, 1'b0,1'b0, 32'h2000, 8'd0, 1'b1,1'b1, 32'hB1, 1'b1,1'b0,1'b0,2'd0,1'b0};
    vt[10] = '{1'b0, 32'h0,    8'd0, 1'b0, 1'b1, 32'hB1, 1'b1,1'b1,1'b0,1'b0,2'd0, 1'b0,1'b0, 32'h2000, 8'd0, 1'b0,1'b0, 32'h0,  1'b0,1'b1,1'b0,2'd0,1'b0};
    vt[11] = '{1'b0, 32'h0,    8'd0, 1'b0, 1'b0, 32'h0,  1'b0,1'b0,1'b1,1'b0,2'd2, 1'b0,1'b0, 32'h2000, 8'd0, 1'b0,1'b0, 32'h0,  1'b0,1'b1,1'b0,2'd0,1'b0};
    vt[12] = '{1'b0, 32'h0,    8'd0, 1'b0, 1'b0, 32'h0,  1'b0,1'b0,1'b0,1'b0,2'd0, 1'b1,1'b0, 32'h2000, 8'd0, 1'b0,1'b0, 32'h0,  1'b0,1'b0,1'b1,2'd2,1'b1};
    vt[13] = '{1'b0, 32'h0,    8'd0, 1'b0, 1'b0, 32'h0,  1'b0,1'b0,1'b0,1'b0,2'd0, 1'b1,1'b0, 32'h2000, 8'd0, 1'b0,1'b0, 32'h0,  1'b0,1'b0,1'b0,2'd2,1'b1};
    vt[14] = '{1'b1, 32'h3000, 8'd1, 1'b0, 1'b1, 32'hC0, 1'b0,1'b1,1'b0,1'b0,2'd0, 1'b1,1'b0, 32'h2000, 8'd0, 1'b0,1'b0, 32'h0,  1'b0,1'b0,1'b0,2'd2,1'b1};
    for (int i = 15; i < 20; i++)
      vt[i] = '{1'b0, 32'h0,   8'd0, 1'b0, 1'b1, 32'hC0, 1'b0,1'b1,1'b0,1'b0,2'd0, 1'b0,1'b1, 32'h3000, 8'd1, 1'b0,1'b0, 32'h0,  1'b0,1'b0,1'b0,2'd2,1'b1};
    vt[20] = '{1'b0, 32'h0,    8'd0, 1'b0, 1'b1, 32'hC0, 1'b1,1'b1,1'b0,1'b0,2'd0, 1'b0,1'b1, 32'h3000, 8'd1, 1'b0,1'b0, 32'h0,  1'b0,1'b0,1'b0,2'd2,1'b1};
    vt[21] = '{1'b0, 32'h0,    8'd0, 1'b0, 1'b1, 32'hC0, 1'b0,1'b1,1'b0,1'b0,2'd0, 1'b0,1'b0, 32'h3000, 8'd1, 1'b1,1'b0, 32'hC0, 1'b1,1'b0,1'b0,2'd2,1'b1};
    vt[22] = '{1'b0, 32'h0,    8'd0, 1'b0, 1'b1, 32'hC1, 1'b0,1'b1,1'b0,1'b0,2'd0, 1'b0,1'b0, 32'h3000, 8'd1, 1'b1,1'b1, 32'hC1, 1'b1,1'b0,1'b0,2'd2,1'b1};
    vt[23] = '{1'b0, 32'h0,    8'd0, 1'b0, 1'b0, 32'h0,  1'b0,1'b1,1'b1,1'b0,2'd0, 1'b0,1'b0, 32'h3000, 8'd1, 1'b0,1'b0, 32'h0,  1'b0,1'b1,1'b0,2'd2,1'b1};
    vt[24] = '{1'b0, 32'h0,    8'd0, 1'b0, 1'b0, 32'h0,  1'b0,1'b0,1'b0,1'b0,2'd0, 1'b1,1'b0, 32'h3000, 8'd1, 1'b0,1'b0, 32'h0,  1'b0,1'b0,1'b1,2'd0,1'b0};

    // reset: cmd_ready must read low while rst is high
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("cmd_ready_in_reset", {127'd0, b0.cmd_ready}, 128'd0);
    tick();
    rst = 1'b0;

    // per-cycle table
    for (int i = 0; i < 25; i++) begin
      b0.cmd_valid = vt[i].cv; b0.cmd_addr = vt[i].addr; b0.cmd_len = vt[i].len; b0.cmd_id = vt[i].id;
      b0.wr_valid = vt[i].wv; b0.wr_data = vt[i].wd;
      b0.m_axi_awready = vt[i].awr; b0.m_axi_wready = vt[i].wr; b0.m_axi_bvalid = vt[i].bv;
      b0.m_axi_bid = vt[i].bid; b0.m_axi_bresp = vt[i].bresp;
      @(negedge clk);
      act = {46'd0, b0.cmd_ready, b0.m_axi_awvalid, b0.m_axi_awaddr, b0.m_axi_awlen,
             b0.m_axi_wvalid, b0.m_axi_wlast, (b0.m_axi_wvalid ? b0.m_axi_wdata : 32'h0),
             b0.wr_ready, b0.m_axi_bready, b0.done_valid, b0.done_resp, b0.done_idmis};
      exp = {46'd0, vt[i].ecr, vt[i].eaw, vt[i].eaddr, vt[i].elen, vt[i].ewv, vt[i].ewl, vt[i].ewd,
             vt[i].ewrr, vt[i].ebr, vt[i].edn, vt[i].eresp, vt[i].eidm};
      chk($sformatf("vec[%0d]", i), act, exp);
      $display("vec %0d cmd_v=%0b awv=%0b wv=%0b bready=%0b done=%0b",
               i, vt[i].cv, b0.m_axi_awvalid, b0.m_axi_wvalid, b0.m_axi_bready, b0.done_valid);
      tick();
    end
    b0.wr_valid = 0; b0.m_axi_wready = 0;

    // constant AW fields, AXI4 32-bit build
    chk("aw_const_axi4", {107'd0, b0.m_axi_awsize, b0.m_axi_awburst, b0.m_axi_awlock,
                           b0.m_axi_awcache, b0.m_axi_awprot, b0.m_axi_awqos},
        {107'd0, 3'd2, 2'b01, 1'b0, 4'b0011, 3'd0, 4'd0});

    // len=3 with W backpressure and a gapped source
    base = beats0.size();
    burst0(32'h4000, 8'd3, 1'b1, 32'hD0, 1'b1);
    chk("gap_beat_count", 128'(beats0.size() - base), 128'd4);
    for (int i = 0; i < 4; i++) begin
      if (base + i < beats0.size())
        chk($sformatf("gap_beat[%0d]", i), {95'd0, beats0[base+i].d, beats0[base+i].l},
            {95'd0, 32'hD0 + 32'(i), (i == 3) ? 1'b1 : 1'b0});
    end
    chk("gap_protocol_errors", 128'(proto_err0), 128'd0);

    // back-to-back len 1 then len 7
    base = beats0.size(); ab = aw_len0.size(); db = done_cyc0.size();
    burst0(32'h6000, 8'd1, 1'b0, 32'hE0, 1'b0);
    burst0(32'h7000, 8'd7, 1'b1, 32'hF0, 1'b0);
    chk("b2b_aw_count", 128'(aw_len0.size() - ab), 128'd2);
    if (aw_len0.size() - ab == 2 && done_cyc0.size() - db == 2) begin
      chk("b2b_awlen0", 128'(aw_len0[ab]), 128'd1);
      chk("b2b_awlen1", 128'(aw_len0[ab+1]), 128'd7);
      chk("b2b_aw_after_done", {127'd0, aw_cyc0[ab+1] > done_cyc0[db]}, 128'd1);
    end
    chk("b2b_beat_count", 128'(beats0.size() - base), 128'd10);
    for (int i = 0; i < 10; i++) begin
      if (base + i < beats0.size())
        chk($sformatf("b2b_beat[%0d]", i), {95'd0, beats0[base+i].d, beats0[base+i].l},
            {95'd0, (i < 2) ? 32'hE0 + 32'(i) : 32'hF0 + 32'(i - 2), (i == 1 || i == 9) ? 1'b1 : 1'b0});
    end

    // AXI3 build, len=15
    base = beats1.size(); ab = aw_len1.size(); seen = 1'b0; k = 0;
    b1.cmd_valid = 1; b1.cmd_addr = 32'h8000; b1.cmd_len = 4'hF; b1.cmd_id = 1'b1;
    b1.m_axi_awready = 1; b1.m_axi_wready = 1; b1.wr_valid = 1; b1.m_axi_bvalid = 1; b1.m_axi_bid = 1'b1;
    while (!seen && k < 100) begin
      b1.wr_data = 32'h100 + 32'(beats1.size() - base);
      @(negedge clk);
      if (b1.done_valid) seen = 1'b1;
      tick();
      b1.cmd_valid = 0;
      k++;
    end
    b1.wr_valid = 0; b1.m_axi_bvalid = 0; b1.m_axi_awready = 0; b1.m_axi_wready = 0;
    $display("axi3 burst len=15 beats=%0d cycles=%0d", beats1.size() - base, k);
    chk("axi3_done_seen", {127'd0, seen}, 128'd1);
    chk("axi3_beat_count", 128'(beats1.size() - base), 128'd16);
    for (int i = 0; i < 16; i++) begin
      if (base + i < beats1.size())
        chk($sformatf("axi3_beat[%0d]", i), {95'd0, beats1[base+i].d, beats1[base+i].l},
            {95'd0, 32'h100 + 32'(i), (i == 15) ? 1'b1 : 1'b0});
    end
    if (aw_len1.size() - ab == 1) chk("axi3_awlen", 128'(aw_len1[ab]), 128'd15);
    else chk("axi3_aw_count", 128'(aw_len1.size() - ab), 128'd1);
    chk("axi3_awlock", 128'(b1.m_axi_awlock), 128'd0);
    chk("axi3_wid_eq_awid_errors", 128'(wid_err), 128'd0);

    // reset asserted while beat 3 of 8 is on the bus
    base = beats0.size(); nd = done_cyc0.size(); k = 0;
    b0.cmd_valid = 1; b0.cmd_addr = 32'h5000; b0.cmd_len = 8'd7; b0.cmd_id = 1'b1;
    b0.m_axi_awready = 1; b0.m_axi_wready = 1; b0.wr_valid = 1; b0.wr_data = 32'h50; b0.m_axi_bvalid = 0;
    while (beats0.size() - base < 2 && k < 50) begin
      tick();
      b0.cmd_valid = 0;
      b0.wr_data = 32'h50 + 32'(beats0.size() - base);
      k++;
    end
    chk("rst_beat3_presented", {127'd0, b0.m_axi_wvalid}, 128'd1);
    #2 rst = 1'b1;
    #1;
    chk("rst_outputs_drop", {122'd0, b0.m_axi_awvalid, b0.m_axi_wvalid, b0.wr_ready,
                             b0.m_axi_bready, b0.done_valid, b0.cmd_ready}, 128'd0);
    tick();
    tick();
    rst = 1'b0;
    b0.wr_valid = 0; b0.m_axi_awready = 0; b0.m_axi_wready = 0;
    @(negedge clk);
    chk("rst_release_state", {87'd0, b0.cmd_ready, b0.m_axi_awaddr, b0.m_axi_awlen}, {87'd0, 1'b1, 32'h0, 8'd0});
    repeat (6) tick();
    chk("rst_no_done", 128'(done_cyc0.size() - nd), 128'd0);
    chk("rst_beats_stopped", 128'(beats0.size() - base), 128'd2);
    $display("reset mid-burst after %0d beats", beats0.size() - base);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/axi4_burst_write_master.md
# axi4_burst_write_master

Single-outstanding AXI4/AXI3 burst write initiator. It is the master-side counterpart of the interconnect's slave-slot write channels (AW/W/B). It accepts a write command (address, beat count, ID) plus a beat stream from local logic, drives one INCR burst onto the `m_axi_*` write channels, and reports the B response. It sits between a DMA/control engine and an interconnect slave slot.

## Interface
- `C_AXI_ID_WIDTH`, default 1: width of AWID, WID and BID.
- `C_AXI_ADDR_WIDTH`, default 32: address width.
- `C_AXI_DATA_WIDTH`, default 32: data width; allowed values 32, 64, 128. The strobe width is `C_AXI_DATA_WIDTH/8`.
- `C_AXI_PROTOCOL`, default 0: 0 selects AXI4, 1 selects AXI3. This sets LW (LEN width: 4 for AXI3, otherwise 8) and KW (LOCK width: 2 for AXI3, otherwise 1).

Ports (name, direction, width, meaning):
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `cmd_valid` in 1 / `cmd_ready` out 1: command handshake.
- `cmd_addr` in ADDR: burst start address.
- `cmd_len` in LW: beats minus 1.
- `cmd_id` in ID: transaction ID.
- `wr_data` in DATA, `wr_strb` in DATA/8, `wr_valid` in 1 / `wr_ready` out 1: local beat stream.
- `done_valid` out 1: one-cycle pulse when the burst completes.
- `done_resp` out 2: BRESP captured for the burst.
- `done_idmis` out 1: BID differed from the issued ID.
- `m_axi_awid` ID, `m_axi_awaddr` ADDR, `m_axi_awlen` LW, `m_axi_awsize` 3, `m_axi_awburst` 2, `m_axi_awlock` KW, `m_axi_awcache` 4, `m_axi_awprot` 3, `m_axi_awqos` 4, `m_axi_awvalid` 1: all outputs. `m_axi_awready` 1: input.
- `m_axi_wid` ID, `m_axi_wdata` DATA, `m_axi_wstrb` DATA/8, `m_axi_wlast` 1, `m_axi_wvalid` 1: all outputs. `m_axi_wready` 1: input.
- `m_axi_bid` ID, `m_axi_bresp` 2, `m_axi_bvalid` 1: all inputs. `m_axi_bready` 1: output.

## Operation
- FSM states: IDLE, ADDR, DATA, RESP.
- IDLE:
  - `cmd_ready`=1.
  - On `cmd_valid`: latch addr, len and id into registers, clear the beat counter, go to ADDR.
- ADDR:
  - `m_axi_awvalid`=1 (registered).
  - On `m_axi_awready`: go to DATA.
- DATA: the beat path is combinational.
  - `m_axi_wvalid` = `wr_valid`.
  - `wr_ready` = `m_axi_wready`.
  - `m_axi_wdata` and `m_axi_wstrb` pass through.
  - `m_axi_wlast` = (counter == latched len).
  - The counter (LW bits) increments on each W handshake.
  - The handshake on the last beat moves the FSM to RESP.
- RESP:
  - `m_axi_bready`=1.
  - On `m_axi_bvalid`: capture `bresp`; set `done_idmis` = (`bid` != latched id); pulse `done_valid` for one cycle (registered); return to IDLE.
- Outside DATA, `m_axi_wvalid`=0 and `wr_ready`=0. The local source may hold `wr_valid` high early; no beat is consumed before AW is accepted.
- Constant channel fields:
  - `awsize` = log2(DATA/8)
  - `awburst` = 2'b01 (INCR)
  - `awlock` = 0
  - `awcache` = 4'b0011
  - `awprot` = 0
  - `awqos` = 0
- `awid` and `wid` both come from the latched id. `wid` is meaningful only for AXI3.
- `awaddr` and `awlen` come from the latched registers and are stable while `awvalid` is high.
- Only one burst is in flight at a time. 4 KB boundary crossing is the caller's responsibility and is not checked.

## Timing
- Reset values:
  - State: IDLE.
  - `cmd_ready`=1 after reset release; 0 while `rst` is high.
  - All `*valid`, `m_axi_bready`, `done_valid` and `done_idmis` = 0.
  - `done_resp`=0; address, len and id registers = 0.
- Command accepted at edge N → `awvalid` high from cycle N+1. It stays high until the `awready` edge and drops the following cycle.
- First W beat can complete in the cycle after the AW handshake. With zero backpressure, an L-beat burst takes 1 (AW) + L (W) + 1 (B) cycles.
- `done_valid` is high in the cycle after the B handshake; `cmd_ready` is high in that same cycle (back-to-back throughput).
- Reset mid-burst: all valids drop asynchronously and state returns to IDLE. No completion is reported. The system must reset the slave side too.
- `cmd_len`=0: a single beat with `wlast`=1 on that beat.
- Counter wrap is impossible: it is bounded by len ≤ 2^LW−1.

## Test plan
- AXI4, `cmd_addr`=0x1000, len=0, id=1, `awready`/`wready`/`bvalid` always high:
  - `awvalid` 1 cycle with `awlen`=0, `awsize`=2, `awburst`=1.
  - One W beat with `wlast`=1.
  - `done_valid` pulse with resp=0, idmis=0.
  - 4 cycles total from command to done.
- len=3 with `wready` low on alternate cycles and `wr_valid` gapped: exactly 4 beats, data order preserved, `wlast` only on beat 4, no beat while `wready`=0.
- `awready` held low for 5 cycles while `wr_valid`=1: `awaddr`/`awlen` stable, `wr_ready`=0 and `wvalid`=0 until AW completes.
- `bresp`=2'b10 with `bid`=0 against issued id=1: `done_resp`=2, `done_idmis`=1, then back in IDLE.
- Two back-to-back commands (len 1 and len 7): the second `awvalid` occurs only after the first `done_valid`; correct `awlen` each time.
- AXI3 build (`C_AXI_PROTOCOL`=1), len=15: 16 beats, `awlock` 2 bits = 0, `wid`=`awid`.
- Assert `rst` on beat 3 of 8: all valids 0 immediately, `cmd_ready`=1 after release, no `done_valid`.
